// File: rtl/qpoint_pkg.sv
// Shared Q-format helpers for the fixed-point MAC datapath: saturation bounds,
// rounding constant and a width sanity check usable inside any generate region.
`ifndef QPOINT_PKG_SV
`define QPOINT_PKG_SV

`define QPOINT_CHECK_WIDTHS(IW, OW, SH) \
  if (((OW) > (IW)) || ((SH) < 0) || ((SH) >= (IW))) begin : g_qfmt_bad \
    $error("qpoint: illegal Q-format width/shift combination"); \
  end

package qpoint_pkg;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Half of one output LSB, so an arithmetic shift rounds ties toward +inf.
  function automatic longint rnd_const(input int sh);
    if (sh == 0) return longint'(0);
    return longint'(1) <<< (sh - 1);
  endfunction

endpackage

`endif

// File: rtl/qpoint_sat.sv
// Combinational signed saturator: clips a wide value into OUT_WIDTH bits and
// flags whether clipping happened.
module qpoint_sat
  import qpoint_pkg::*;
#(
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0]  din_i,
  output logic signed [OUT_WIDTH-1:0] dout_o,
  output logic                        sat_o
);

  localparam logic signed [IN_WIDTH-1:0] MAX_V = IN_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] MIN_V = IN_WIDTH'(sat_min(OUT_WIDTH));

  always_comb begin
    dout_o = din_i[OUT_WIDTH-1:0];
    sat_o  = 1'b0;
    if (din_i > MAX_V) begin
      dout_o = MAX_V[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end else if (din_i < MIN_V) begin
      dout_o = MIN_V[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/qpoint_requant.sv
// Two-stage valid/ready re-quantizer: round (add half LSB, arithmetic shift),
// then saturate to OUT_WIDTH, with sticky saturation statistics.
module qpoint_requant
  import qpoint_pkg::*;
#(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        clr_stats,
  output logic [CNT_WIDTH-1:0]        sat_cnt,
  output logic                        sat_flag
);

  `QPOINT_CHECK_WIDTHS(IN_WIDTH, OUT_WIDTH, SHIFT)

  localparam int S1_W = IN_WIDTH + 1;
  localparam logic signed [S1_W-1:0] RND = S1_W'(rnd_const(SHIFT));

  logic signed [S1_W-1:0]      r_d, s1_d, s1_q;
  logic                        s1_vld_q;
  logic signed [OUT_WIDTH-1:0] out_data_d, out_data_q;
  logic                        out_sat_d, out_sat_q, out_vld_q;
  logic [CNT_WIDTH-1:0]        sat_cnt_d, sat_cnt_q;
  logic                        sat_flag_d, sat_flag_q;
  logic                        s1_load, s2_load, out_fire;

  assign s2_load  = !out_vld_q || out_ready;
  assign s1_load  = !s1_vld_q || s2_load;
  assign in_ready = s1_load;
  assign out_fire = out_vld_q && out_ready;

  // Stage 1: round
  assign r_d  = S1_W'(in_data) + RND;
  assign s1_d = r_d >>> SHIFT;

  // Stage 2: saturate
  qpoint_sat #(
    .IN_WIDTH (S1_W),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_sat (
    .din_i (s1_q),
    .dout_o(out_data_d),
    .sat_o (out_sat_d)
  );

  always_comb begin
    sat_cnt_d  = sat_cnt_q;
    sat_flag_d = sat_flag_q;
    if (clr_stats) begin
      sat_cnt_d  = '0;
      sat_flag_d = 1'b0;
    end else if (out_fire && out_sat_q) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_q != {CNT_WIDTH{1'b1}}) sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_vld_q   <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      sat_cnt_q  <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_vld_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      // Data holds its last value when the output stage drains empty.
      if (s2_load) begin
        out_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          out_data_q <= out_data_d;
          out_sat_q  <= out_sat_d;
        end
      end
      sat_cnt_q  <= sat_cnt_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_vld_q;
  assign sat_cnt   = sat_cnt_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_qpoint_requant.sv
// Directed bench for qpoint_requant: plain saturation, SHIFT=4 rounding,
// backpressure, sticky counter with clear, and asynchronous reset mid-stream.
module tb_qpoint_requant;

  logic clk;
  logic rst_n;

  logic signed [16:0] a_in_data, b_in_data, c_in_data;
  logic               a_in_valid, b_in_valid, c_in_valid;
  logic               a_in_ready, b_in_ready, c_in_ready;
  logic signed [15:0] a_out_data, b_out_data, c_out_data;
  logic               a_out_sat, b_out_sat, c_out_sat;
  logic               a_out_valid, b_out_valid, c_out_valid;
  logic               a_out_ready, b_out_ready, c_out_ready;
  logic               a_clr, b_clr, c_clr;
  logic [15:0]        a_cnt, b_cnt;
  logic [1:0]         c_cnt;
  logic               a_flag, b_flag, c_flag;

  int ncmp = 0;
  int nerr = 0;

  qpoint_requant #(.IN_WIDTH(17), .OUT_WIDTH(16), .SHIFT(0), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_sat(a_out_sat),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .clr_stats(a_clr),
    .sat_cnt(a_cnt), .sat_flag(a_flag)
  );

  qpoint_requant #(.IN_WIDTH(17), .OUT_WIDTH(16), .SHIFT(4), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_sat(b_out_sat),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .clr_stats(b_clr),
    .sat_cnt(b_cnt), .sat_flag(b_flag)
  );

  qpoint_requant #(.IN_WIDTH(17), .OUT_WIDTH(16), .SHIFT(0), .CNT_WIDTH(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_sat(c_out_sat),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .clr_stats(c_clr),
    .sat_cnt(c_cnt), .sat_flag(c_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  int a_vec[5]   = '{1234, 65535, -65536, 32767, -32768};
  int a_exp[5]   = '{1234, 32767, -32768, 32767, -32768};
  int a_sat[5]   = '{0, 1, 1, 0, 0};
  int b_vec[5]   = '{24, -24, -25, 7, 8};
  int b_exp[5]   = '{2, -1, -2, 0, 1};
  int bp_vec[4]  = '{10, 20, 30, 40};

  initial begin
    logic take;
    int   idx;
    int   acc;
    int   got[$];
    int   hs_cyc[$];

    rst_n = 1'b0;
    a_in_data = '0; b_in_data = '0; c_in_data = '0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
    tick();
    tick();

    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_sat", a_out_sat, 0);
    check("rst_sat_cnt", a_cnt, 0);
    check("rst_sat_flag", a_flag, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", a_in_ready, 1);

    // Back-to-back stream through the SHIFT=0 and SHIFT=4 instances.
    for (int i = 0; i < 6; i++) begin
      a_in_valid = (i < 5);
      b_in_valid = (i < 5);
      if (i < 5) begin
        a_in_data = 17'(a_vec[i]);
        b_in_data = 17'(b_vec[i]);
      end
      tick();
      if (i == 0) check("lat_not_yet", a_out_valid, 0);
      if (i > 0) begin
        check("s0_valid", a_out_valid, 1);
        check("s0_data", a_out_data, a_exp[i-1]);
        check("s0_sat", a_out_sat, a_sat[i-1]);
        check("s4_valid", b_out_valid, 1);
        check("s4_data", b_out_data, b_exp[i-1]);
        check("s4_sat", b_out_sat, 0);
      end
    end
    tick();
    check("s0_sat_cnt", a_cnt, 2);
    check("s0_sat_flag", a_flag, 1);
    check("s0_empty_valid", a_out_valid, 0);
    check("s0_empty_hold", a_out_data, -32768);
    check("s4_sat_cnt", b_cnt, 0);
    check("s4_sat_flag", b_flag, 0);

    // Backpressure: only two samples fit while the output is stalled.
    a_out_ready = 1'b0;
    idx = 0;
    acc = 0;
    a_in_valid = 1'b1;
    a_in_data = 17'(bp_vec[0]);
    for (int c = 0; c < 6; c++) begin
      take = a_in_valid && a_in_ready;
      tick();
      if (take) begin
        acc++;
        idx++;
        if (idx < 4) a_in_data = 17'(bp_vec[idx]);
        else a_in_valid = 1'b0;
      end
      if (c >= 2) check("bp_hold_data", a_out_data, 10);
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready", a_in_ready, 0);
    check("bp_out_valid", a_out_valid, 1);
    a_out_ready = 1'b1;
    #1;
    check("bp_ready_comb", a_in_ready, 1);

    for (int c = 0; c < 8; c++) begin
      take = a_in_valid && a_in_ready;
      if (a_out_valid && a_out_ready) begin
        got.push_back(int'(a_out_data));
        hs_cyc.push_back(c);
      end
      tick();
      if (take) begin
        idx++;
        if (idx < 4) a_in_data = 17'(bp_vec[idx]);
        else a_in_valid = 1'b0;
      end
    end
    check("bp_drain_count", got.size(), 4);
    for (int k = 0; k < got.size(); k++) check("bp_drain_order", got[k], bp_vec[k]);
    if (hs_cyc.size() == 4) check("bp_drain_rate", hs_cyc[3] - hs_cyc[0], 3);

    // Two-bit counter sticks at 3, then clear wins over a coincident saturation.
    for (int i = 0; i < 6; i++) begin
      c_in_valid = (i < 5);
      c_in_data = 17'sd65535;
      tick();
    end
    tick();
    check("cnt_sticky", c_cnt, 3);
    check("cnt_flag", c_flag, 1);
    c_out_ready = 1'b0;
    c_in_valid = 1'b1;
    c_in_data = -17'sd65536;
    tick();
    c_in_valid = 1'b0;
    tick();
    check("cnt_6th_valid", c_out_valid, 1);
    check("cnt_6th_sat", c_out_sat, 1);
    c_clr = 1'b1;
    c_out_ready = 1'b1;
    tick();
    c_clr = 1'b0;
    check("clr_cnt", c_cnt, 0);
    check("clr_flag", c_flag, 0);
    check("clr_handshake", c_out_valid, 0);

    // Asynchronous reset with two samples in flight.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 17'sd100;
    tick();
    a_in_data = 17'sd200;
    tick();
    a_in_valid = 1'b0;
    check("mid_inflight", a_out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", a_out_valid, 0);
    check("mid_rst_data", a_out_data, 0);
    check("mid_rst_in_ready", a_in_ready, 1);
    check("mid_rst_cnt", a_cnt, 0);
    check("mid_rst_flag", a_flag, 0);
    tick();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    tick();
    check("post_rst_ready", a_in_ready, 1);
    a_in_valid = 1'b1;
    a_in_data = 17'sd5;
    tick();
    a_in_valid = 1'b0;
    check("post_rst_early", a_out_valid, 0);
    tick();
    check("post_rst_valid", a_out_valid, 1);
    check("post_rst_data", a_out_data, 5);
    tick();
    check("post_rst_no_stale", a_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
